// File: rtl/ahb_arbiter_pkg.sv
// Shared AHB-lite transfer/burst encodings and the burst-length decode.
// Latency: none (constants and a pure function).
// Backpressure: not applicable.
package ahb_arbiter_pkg;

  localparam logic [1:0] TR_IDLE   = 2'd0;
  localparam logic [1:0] TR_BUSY   = 2'd1;
  localparam logic [1:0] TR_NONSEQ = 2'd2;
  localparam logic [1:0] TR_SEQ    = 2'd3;

  localparam logic [2:0] BU_SINGLE = 3'd0;
  localparam logic [2:0] BU_INCR   = 3'd1;
  localparam logic [2:0] BU_WRAP4  = 3'd2;
  localparam logic [2:0] BU_INCR4  = 3'd3;
  localparam logic [2:0] BU_WRAP8  = 3'd4;
  localparam logic [2:0] BU_INCR8  = 3'd5;
  localparam logic [2:0] BU_WRAP16 = 3'd6;
  localparam logic [2:0] BU_INCR16 = 3'd7;

  // Fixed-length bursts return their beat count; SINGLE and INCR return 0
  // because they never end on a counted beat.
  function automatic logic [4:0] burst_len(input logic [2:0] hburst);
    logic [4:0] len;
    case (hburst)
      BU_WRAP4, BU_INCR4:   len = 5'd4;
      BU_WRAP8, BU_INCR8:   len = 5'd8;
      BU_WRAP16, BU_INCR16: len = 5'd16;
      default:              len = 5'd0;
    endcase
    return len;
  endfunction

endpackage

// File: rtl/ahb_rr_pick.sv
// Round-robin picker: first requester after the last owner, owner itself last.
// Latency: purely combinational.
// Backpressure: none; vld=0 when no master requests.
module ahb_rr_pick #(
  parameter int NUM_M = 4
) (
  input  logic [NUM_M-1:0] req,
  input  logic [3:0]       last,
  output logic [3:0]       next_idx,
  output logic             vld
);

  logic [15:0] req_ext;
  logic [4:0]  idx;

  assign req_ext = 16'(req);

  // Walk last+1 .. last+NUM_M modulo NUM_M and keep the first hit.
  always_comb begin
    vld      = 1'b0;
    next_idx = 4'd0;
    idx      = 5'd0;
    for (int i = 1; i <= NUM_M; i++) begin
      idx = {1'b0, last} + 5'(i);
      if (idx >= 5'(NUM_M)) idx = idx - 5'(NUM_M);
      if (!vld && req_ext[idx[3:0]]) begin
        vld      = 1'b1;
        next_idx = idx[3:0];
      end
    end
  end

endmodule

// File: rtl/ahb_arbiter.sv
// Round-robin AHB-lite bus arbiter with burst, lock and error-cancel awareness.
// Latency: decision combinational in cycle T, HMASTER/HGRANT update at the end of T.
// Backpressure: HREADY=0 freezes ownership, the beat counter and HMASTER_D.
module ahb_arbiter
  import ahb_arbiter_pkg::*;
#(
  parameter int NUM_M = 4
) (
  input  logic             HCLK,
  input  logic             HRESETn,
  input  logic [NUM_M-1:0] HBUSREQ,
  input  logic [NUM_M-1:0] HLOCK,
  input  logic [1:0]       HTRANS,
  input  logic [2:0]       HBURST,
  input  logic             HREADY,
  input  logic             HRESP,
  output logic [NUM_M-1:0] HGRANT,
  output logic [3:0]       HMASTER,
  output logic [3:0]       HMASTER_D,
  output logic             HMASTLOCK
);

  logic [4:0]  beat;
  logic [4:0]  len;
  logic        err_pend;
  logic        boundary;
  logic        arb_ok;
  logic        lock_own;
  logic [15:0] lock_ext;
  logic [3:0]  pick_idx;
  logic        pick_vld;

  // Widen HLOCK so any 4-bit owner index is a legal select.
  assign lock_ext  = 16'(HLOCK);
  assign lock_own  = lock_ext[HMASTER];
  assign HMASTLOCK = lock_own;
  assign len       = burst_len(HBURST);

  ahb_rr_pick #(.NUM_M(NUM_M)) u_pick (
    .req      (HBUSREQ),
    .last     (HMASTER),
    .next_idx (pick_idx),
    .vld      (pick_vld)
  );

  // Legal hand-over points: idle bus, end of single/undefined-length
  // transfers, last beat of a fixed burst, or an error-cancelled burst.
  always_comb begin
    boundary = 1'b0;
    if (HTRANS == TR_IDLE) boundary = 1'b1;
    if (HTRANS == TR_NONSEQ && HBURST == BU_SINGLE) boundary = 1'b1;
    if ((HTRANS == TR_NONSEQ || HTRANS == TR_SEQ) && HBURST == BU_INCR) boundary = 1'b1;
    if (HTRANS == TR_SEQ && len != 5'd0 && beat == len - 5'd1) boundary = 1'b1;
    if (err_pend) boundary = 1'b1;
    // A locked owner is never pre-empted, even by an error cancel.
    arb_ok = HREADY && boundary && !lock_own;
  end

  // Count accepted beats of the current burst; an error abandons it.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      beat <= 5'd0;
    end else if (HREADY) begin
      if (err_pend) begin
        beat <= 5'd0;
      end else begin
        case (HTRANS)
          TR_NONSEQ: beat <= 5'd1;
          TR_SEQ:    beat <= beat + 5'd1;
          TR_IDLE:   beat <= 5'd0;
          default:   beat <= beat;
        endcase
      end
    end
  end

  // Remember the first (HREADY=0) cycle of a two-cycle ERROR response.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      err_pend <= 1'b0;
    end else if (HREADY) begin
      err_pend <= 1'b0;
    end else if (HRESP) begin
      err_pend <= 1'b1;
    end
  end

  // Address-phase owner moves only at arbitration points; data-phase owner
  // follows one accepted transfer later so wait states keep HWDATA steered.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      HMASTER   <= 4'd0;
      HMASTER_D <= 4'd0;
    end else if (HREADY) begin
      HMASTER_D <= HMASTER;
      if (arb_ok) HMASTER <= pick_vld ? pick_idx : 4'd0;
    end
  end

  // One-hot grant decoded from the registered owner.
  always_comb begin
    HGRANT = '0;
    for (int i = 0; i < NUM_M; i++) HGRANT[i] = (HMASTER == 4'(i));
  end

endmodule

// File: tb/tb_ahb_arbiter.sv
// Scoreboard bench for ahb_arbiter: directed AHB-lite traffic with expected owners.
// Latency: expectations are popped one clock edge after they are driven.
// Backpressure: HREADY wait states are part of the stimulus.
module tb_ahb_arbiter;
  import ahb_arbiter_pkg::*;

  localparam int NUM_M = 4;

  logic             HCLK = 1'b0;
  logic             HRESETn;
  logic [NUM_M-1:0] HBUSREQ;
  logic [NUM_M-1:0] HLOCK;
  logic [1:0]       HTRANS;
  logic [2:0]       HBURST;
  logic             HREADY;
  logic             HRESP;
  logic [NUM_M-1:0] HGRANT;
  logic [3:0]       HMASTER;
  logic [3:0]       HMASTER_D;
  logic             HMASTLOCK;

  typedef struct packed {
    logic [3:0] m;
    logic [3:0] md;
  } exp_t;

  exp_t       sb_q[$];
  int         n_vec = 0;
  int         n_err = 0;
  logic [3:0] cur_m;

  ahb_arbiter #(.NUM_M(NUM_M)) dut (
    .HCLK      (HCLK),
    .HRESETn   (HRESETn),
    .HBUSREQ   (HBUSREQ),
    .HLOCK     (HLOCK),
    .HTRANS    (HTRANS),
    .HBURST    (HBURST),
    .HREADY    (HREADY),
    .HRESP     (HRESP),
    .HGRANT    (HGRANT),
    .HMASTER   (HMASTER),
    .HMASTER_D (HMASTER_D),
    .HMASTLOCK (HMASTLOCK)
  );

  always #5 HCLK = ~HCLK;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Scoreboard side: compare owners just after each active edge.
  always @(posedge HCLK) begin
    exp_t       e;
    logic [3:0] g;
    #1;
    if (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      g = 4'b0001 << e.m;
      chk("hmaster", 32'(HMASTER), 32'(e.m));
      chk("hmaster_d", 32'(HMASTER_D), 32'(e.md));
      chk("hgrant", 32'(HGRANT), 32'(g));
    end
  end

  // Drive one bus cycle at the falling edge; em/emd are the owners expected
  // after the next rising edge.
  task automatic cyc(input logic [1:0] tr, input logic [2:0] bu, input logic rdy,
                     input logic rsp, input logic [3:0] req, input logic [3:0] lk,
                     input logic [3:0] em, input logic [3:0] emd);
    exp_t e;
    @(negedge HCLK);
    HTRANS  = tr;
    HBURST  = bu;
    HREADY  = rdy;
    HRESP   = rsp;
    HBUSREQ = req;
    HLOCK   = lk;
    e.m  = em;
    e.md = emd;
    sb_q.push_back(e);
    #1 chk("hmastlock", 32'(HMASTLOCK), 32'(lk[cur_m[1:0]]));
    cur_m = em;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1);
  end

  initial begin
    HRESETn = 1'b0;
    HTRANS  = TR_IDLE;
    HBURST  = BU_SINGLE;
    HREADY  = 1'b1;
    HRESP   = 1'b0;
    HBUSREQ = '0;
    HLOCK   = '0;
    cur_m   = 4'd0;
    repeat (2) @(posedge HCLK);
    #1;
    chk("rst_hgrant", 32'(HGRANT), 32'h1);
    chk("rst_hmaster", 32'(HMASTER), 32'h0);
    chk("rst_hmaster_d", 32'(HMASTER_D), 32'h0);
    chk("rst_beat", 32'(dut.beat), 32'h0);
    chk("rst_err_pend", 32'(dut.err_pend), 32'h0);
    @(negedge HCLK);
    HRESETn = 1'b1;

    // Idle bus, nobody requesting: stay parked on master 0.
    cyc(TR_IDLE, BU_SINGLE, 1, 0, 4'b0000, 4'b0000, 4'd0, 4'd0);
    cyc(TR_IDLE, BU_SINGLE, 1, 0, 4'b0000, 4'b0000, 4'd0, 4'd0);

    // Masters 1 and 2 alternate on SINGLE transfers.
    cyc(TR_IDLE,   BU_SINGLE, 1, 0, 4'b0110, 4'b0000, 4'd1, 4'd0);
    cyc(TR_NONSEQ, BU_SINGLE, 1, 0, 4'b0110, 4'b0000, 4'd2, 4'd1);
    cyc(TR_NONSEQ, BU_SINGLE, 1, 0, 4'b0110, 4'b0000, 4'd1, 4'd2);
    cyc(TR_NONSEQ, BU_SINGLE, 1, 0, 4'b0110, 4'b0000, 4'd2, 4'd1);

    // Hand to master 1, then INCR8 with master 3 waiting.
    cyc(TR_IDLE,   BU_SINGLE, 1, 0, 4'b0010, 4'b0000, 4'd1, 4'd2);
    cyc(TR_NONSEQ, BU_INCR8,  0, 0, 4'b1010, 4'b0000, 4'd1, 4'd2);
    cyc(TR_NONSEQ, BU_INCR8,  1, 0, 4'b1010, 4'b0000, 4'd1, 4'd1);
    cyc(TR_SEQ,    BU_INCR8,  1, 0, 4'b1010, 4'b0000, 4'd1, 4'd1);
    cyc(TR_SEQ,    BU_INCR8,  1, 0, 4'b1000, 4'b0000, 4'd1, 4'd1);
    cyc(TR_SEQ,    BU_INCR8,  0, 0, 4'b1000, 4'b0000, 4'd1, 4'd1);
    cyc(TR_SEQ,    BU_INCR8,  0, 0, 4'b1000, 4'b0000, 4'd1, 4'd1);
    cyc(TR_SEQ,    BU_INCR8,  1, 0, 4'b1000, 4'b0000, 4'd1, 4'd1);
    cyc(TR_SEQ,    BU_INCR8,  1, 0, 4'b1000, 4'b0000, 4'd1, 4'd1);
    cyc(TR_SEQ,    BU_INCR8,  1, 0, 4'b1000, 4'b0000, 4'd1, 4'd1);
    cyc(TR_SEQ,    BU_INCR8,  1, 0, 4'b1000, 4'b0000, 4'd1, 4'd1);
    cyc(TR_SEQ,    BU_INCR8,  1, 0, 4'b1000, 4'b0000, 4'd3, 4'd1);

    // Master 2 locks through SINGLE/IDLE traffic, then releases on IDLE.
    cyc(TR_IDLE,   BU_SINGLE, 1, 0, 4'b0100, 4'b0100, 4'd2, 4'd3);
    cyc(TR_NONSEQ, BU_SINGLE, 1, 0, 4'b0111, 4'b0100, 4'd2, 4'd2);
    cyc(TR_IDLE,   BU_SINGLE, 1, 0, 4'b0111, 4'b0100, 4'd2, 4'd2);
    cyc(TR_NONSEQ, BU_SINGLE, 1, 0, 4'b0111, 4'b0100, 4'd2, 4'd2);
    cyc(TR_IDLE,   BU_SINGLE, 1, 0, 4'b0111, 4'b0100, 4'd2, 4'd2);
    cyc(TR_NONSEQ, BU_SINGLE, 1, 0, 4'b0111, 4'b0100, 4'd2, 4'd2);
    cyc(TR_IDLE,   BU_SINGLE, 1, 0, 4'b0111, 4'b0000, 4'd0, 4'd2);

    // Master 0 INCR16 hit by ERROR at beat 5; master 1 takes over.
    cyc(TR_NONSEQ, BU_INCR16, 1, 0, 4'b0011, 4'b0000, 4'd0, 4'd0);
    for (int i = 0; i < 4; i++)
      cyc(TR_SEQ, BU_INCR16, 1, 0, 4'b0011, 4'b0000, 4'd0, 4'd0);
    cyc(TR_SEQ, BU_INCR16, 0, 1, 4'b0011, 4'b0000, 4'd0, 4'd0);
    @(posedge HCLK);
    #2;
    chk("err_pend_set", 32'(dut.err_pend), 32'h1);
    chk("beat_at_err", 32'(dut.beat), 32'h5);
    cyc(TR_SEQ, BU_INCR16, 1, 1, 4'b0011, 4'b0000, 4'd1, 4'd0);
    @(posedge HCLK);
    #2;
    chk("beat_after_err", 32'(dut.beat), 32'h0);
    chk("err_pend_clr", 32'(dut.err_pend), 32'h0);

    // Master 3 mid-INCR4 when reset hits between clock edges.
    cyc(TR_IDLE,   BU_SINGLE, 1, 0, 4'b1000, 4'b0000, 4'd3, 4'd1);
    cyc(TR_NONSEQ, BU_INCR4,  1, 0, 4'b1000, 4'b0000, 4'd3, 4'd3);
    cyc(TR_SEQ,    BU_INCR4,  1, 0, 4'b1000, 4'b0000, 4'd3, 4'd3);
    @(posedge HCLK);
    #2;
    HLOCK = 4'b0001;
    #1;
    chk("pre_rst_hmaster", 32'(HMASTER), 32'h3);
    chk("pre_rst_beat", 32'(dut.beat), 32'h2);
    HRESETn = 1'b0;
    #1;
    chk("async_rst_hmaster", 32'(HMASTER), 32'h0);
    chk("async_rst_hgrant", 32'(HGRANT), 32'h1);
    chk("async_rst_hmaster_d", 32'(HMASTER_D), 32'h0);
    chk("async_rst_beat", 32'(dut.beat), 32'h0);
    chk("async_rst_hmastlock", 32'(HMASTLOCK), 32'h1);

    chk("sb_drained", 32'(sb_q.size()), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
